ram_logic: RTL and testbench
============================

// Module: ram_logic
// PURPOSE
//  Ping-pong (double) sample buffer between a streaming producer and a block consumer.
//  Two DEPTH-entry banks: producer fills the write bank while consumer drains the read bank.
//  When the write bank is full the banks swap and the full bank is presented for reading.
//  Sits between the sample front end and downstream block processing.
// PARAMETERS
//  WIDTH       32              sample width in bits (signed data)
//  DEPTH       16              samples per bank; swap occurs after DEPTH writes
//  ADDR_WIDTH  $clog2(DEPTH)   bank address width; counters are ADDR_WIDTH+1 bits
// PORTS
//  clk_i              in   1             single clock, all state on rising edge
//  rst_ni             in   1             asynchronous active-low reset
//  write_data_i       in   WIDTH         signed sample to store
//  write_valid_i      in   1             producer has a sample
//  write_ready_o      out  1             buffer accepts a sample this cycle
//  read_data_o        out  WIDTH         signed sample at read_count_o in read bank (show-ahead)
//  read_ready_i       in   1             consumer takes read_data_o this cycle
//  read_valid_o       out  1             read bank holds unread samples
//  buffer_ready_o     out  1             1-cycle pulse: a full bank has just been swapped in
//  buffer_overflow_o  out  1             sticky: a swap discarded unread samples
//  write_count_o      out  ADDR_WIDTH+1  samples written into current write bank (0..DEPTH)
//  read_count_o       out  ADDR_WIDTH+1  samples read from current read bank (0..DEPTH)
// BEHAVIOUR
//  - Reset (async, rst_ni=0): state=FILL, write bank=0, write_count=0, read_count=0,
//    read_valid=0, write_ready=1, buffer_ready=0, overflow=0, read_data_o=0.
//    Bank contents are not reset.
//  - Write: transfer on rising edge with write_valid_i & write_ready_o.
//    Sample stored at write_count in write bank; write_count++.
//  - FSM FILL: write_ready=1. A transfer that makes write_count==DEPTH -> SWAP_PENDING.
//  - FSM SWAP_PENDING (exactly one cycle): write_ready=0 (inputs ignored).
//    Next edge: swap bank select, write_count=0, read_count=0, read_valid=1,
//    buffer_ready=1 for that one cycle, state -> FILL.
//  - Latency: last write edge E0 -> swap at E1; after E1, write_count=0, read_valid=1, write_ready=1.
//  - Read: read_data_o is combinational from read bank[read_count] while read_valid=1, else 0.
//    Transfer on rising edge with read_valid_o & read_ready_i; read_count++.
//    The transfer that makes read_count==DEPTH clears read_valid.
//  - Reads and writes proceed concurrently on different banks, up to one of each per cycle.
//  - Overflow: at the swap edge, if read_valid=1 and read_count (after any read at that edge)
//    < DEPTH, the unread data is discarded.
//    The swap still happens, buffer_overflow_o sets and stays 1 until reset.
//    Writes are never stalled beyond SWAP_PENDING.
//  - A read accepted at the swap edge completes first; the final read at that edge is not an overflow.
//  - Reset mid-operation aborts everything immediately; partially filled data is lost.
//  - read_valid=0 until the first swap; read_ready_i is ignored while read_valid=0.
// TESTING
//  1 Reset: after rst_ni deassert -> write_ready=1, read_valid=0, write_count=0, read_count=0, overflow=0.
//  2 Write 0x1000..0x100F one per transfer: write_count=i+1 after each of the first 15;
//    two edges after the 16th, write_count=0.
//  3 Fill with 0x2000..0x200F: two edges later write_count=0, read_valid=1; buffer_ready pulsed for 1 cycle.
//  4 Fill with 0x3000..0x300F, swap, read 16 with read_ready=1 -> data 0x3000..0x300F in order;
//    read_valid=0 afterwards.
//  5 Fill 0x4000.., swap; concurrently write 0x5000.. and read -> reads return 0x4000..0x400F,
//    no overflow; second swap exposes 0x5000..0x500F.
//  6 Fill 0x6000.., swap, fill 0x7000.. without reading -> after second swap write_ready=1,
//    write_count=0, buffer_overflow_o=1, reads return 0x7000...

Source files
------------

// File: rtl/ram_logic.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_logic: ping-pong sample buffer, producer fills one bank while the    |
// | consumer drains the other. Rev 1.0                                       |
// +--------------------------------------------------------------------------+
module ram_logic #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [WIDTH-1:0]      write_data_i,
  input  logic                  write_valid_i,
  output logic                  write_ready_o,
  output logic [WIDTH-1:0]      read_data_o,
  input  logic                  read_ready_i,
  output logic                  read_valid_o,
  output logic                  buffer_ready_o,
  output logic                  buffer_overflow_o,
  output logic [ADDR_WIDTH:0]   write_count_o,
  output logic [ADDR_WIDTH:0]   read_count_o
);

  localparam int                CNT_W   = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]  c_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  c_LAST  = CNT_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    FILL         = 1'b0,
    SWAP_PENDING = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_wr_ready;
  logic             w_swap;
  logic             w_wr_fire;
  logic             w_rd_fire;
  logic [CNT_W-1:0] w_rd_cnt_inc;

  logic             r_wr_bank;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] r_rd_cnt;
  logic             r_rd_valid;
  logic             r_buf_ready;
  logic             r_ovf;

  // Both banks live in one array; the top index bit selects the bank.
  logic [WIDTH-1:0] r_mem [2*DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_ready  = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      FILL: begin
        w_wr_ready = 1'b1;
        if (write_valid_i && (r_wr_cnt == c_LAST)) begin
          w_state_nxt = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        w_swap      = 1'b1;
        w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  assign w_wr_fire    = write_valid_i & w_wr_ready;
  assign w_rd_fire    = r_rd_valid & read_ready_i;
  assign w_rd_cnt_inc = r_rd_cnt + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_rd_valid  <= 1'b0;
      r_buf_ready <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_swap) begin
      // A read taking the final sample on this edge empties the bank, so no loss.
      if (r_rd_valid && !(w_rd_fire && (w_rd_cnt_inc == c_DEPTH))) begin
        r_ovf <= 1'b1;
      end
      r_wr_bank   <= ~r_wr_bank;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_rd_valid  <= 1'b1;
      r_buf_ready <= 1'b1;
    end else begin
      r_buf_ready <= 1'b0;
      if (w_wr_fire) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
      if (w_rd_fire) begin
        r_rd_cnt <= w_rd_cnt_inc;
        if (w_rd_cnt_inc == c_DEPTH) begin
          r_rd_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_fire) begin
      r_mem[{r_wr_bank, r_wr_cnt[ADDR_WIDTH-1:0]}] <= write_data_i;
    end
  end

  assign write_ready_o     = w_wr_ready;
  assign read_valid_o      = r_rd_valid;
  assign read_data_o       = r_rd_valid ? r_mem[{~r_wr_bank, r_rd_cnt[ADDR_WIDTH-1:0]}] : '0;
  assign buffer_ready_o    = r_buf_ready;
  assign buffer_overflow_o = r_ovf;
  assign write_count_o     = r_wr_cnt;
  assign read_count_o      = r_rd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ram_logic.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ram_logic: scoreboard bench for the ping-pong buffer. Rev 1.0         |
// +--------------------------------------------------------------------------+
module tb_ram_logic;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [WIDTH-1:0]  write_data_i = '0;
  logic              write_valid_i = 1'b0;
  logic              write_ready_o;
  logic [WIDTH-1:0]  read_data_o;
  logic              read_ready_i = 1'b0;
  logic              read_valid_o;
  logic              buffer_ready_o;
  logic              buffer_overflow_o;
  logic [AW:0]       write_count_o;
  logic [AW:0]       read_count_o;

  always #5 clk_i = ~clk_i;

  ram_logic #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .write_data_i      (write_data_i),
    .write_valid_i     (write_valid_i),
    .write_ready_o     (write_ready_o),
    .read_data_o       (read_data_o),
    .read_ready_i      (read_ready_i),
    .read_valid_o      (read_valid_o),
    .buffer_ready_o    (buffer_ready_o),
    .buffer_overflow_o (buffer_overflow_o),
    .write_count_o     (write_count_o),
    .read_count_o      (read_count_o)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb [$];

  // Reference model: a queue collecting the bank being filled and a frozen copy
  // of the bank offered to the consumer.
  bit               m_pend;
  logic [WIDTH-1:0] m_wq [$];
  logic [WIDTH-1:0] m_rbank [DEPTH];
  int               m_ridx;
  bit               m_rvalid;
  bit               m_ovf;
  bit               m_bufrdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && read_valid_o && read_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read actual=%0h required=none at %0t", read_data_o, $time);
      end else begin
        chk("read_data", 64'(read_data_o), 64'(sb.pop_front()));
      end
    end
  end

  task automatic model_reset();
    m_pend   = 1'b0;
    m_wq.delete();
    m_ridx   = 0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_bufrdy = 1'b0;
  endtask

  task automatic cycle(input bit wv, input logic [WIDTH-1:0] wd, input bit rr);
    bit wr_fire, rd_fire;
    write_valid_i = wv;
    write_data_i  = wd;
    read_ready_i  = rr;
    wr_fire = wv && !m_pend;
    rd_fire = m_rvalid && rr;
    if (rd_fire) sb.push_back(m_rbank[m_ridx]);
    @(negedge clk_i);
    chk("write_ready",  64'(write_ready_o),     64'(!m_pend));
    chk("read_valid",   64'(read_valid_o),      64'(m_rvalid));
    chk("write_count",  64'(write_count_o),     64'(m_wq.size()));
    chk("read_count",   64'(read_count_o),      64'(m_ridx));
    chk("buffer_ready", 64'(buffer_ready_o),    64'(m_bufrdy));
    chk("overflow",     64'(buffer_overflow_o), 64'(m_ovf));
    chk("read_data_view", 64'(read_data_o), m_rvalid ? 64'(m_rbank[m_ridx]) : 64'd0);
    m_bufrdy = 1'b0;
    if (rd_fire) begin
      m_ridx++;
      if (m_ridx == DEPTH) m_rvalid = 1'b0;
    end
    if (m_pend) begin
      if (m_rvalid) m_ovf = 1'b1;
      for (int i = 0; i < DEPTH; i++) m_rbank[i] = m_wq[i];
      m_wq.delete();
      m_ridx   = 0;
      m_rvalid = 1'b1;
      m_bufrdy = 1'b1;
      m_pend   = 1'b0;
    end else if (wr_fire) begin
      m_wq.push_back(wd);
      if (m_wq.size() == DEPTH) m_pend = 1'b1;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    write_valid_i = 1'b0;
    read_ready_i  = 1'b0;
    write_data_i  = '0;
    model_reset();
    #2;
    chk("rst_write_ready",  64'(write_ready_o),     64'd1);
    chk("rst_read_valid",   64'(read_valid_o),      64'd0);
    chk("rst_write_count",  64'(write_count_o),     64'd0);
    chk("rst_read_count",   64'(read_count_o),      64'd0);
    chk("rst_overflow",     64'(buffer_overflow_o), 64'd0);
    chk("rst_buffer_ready", 64'(buffer_ready_o),    64'd0);
    chk("rst_read_data",    64'(read_data_o),       64'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic fill(input logic [WIDTH-1:0] base, input bit rr);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, base + WIDTH'(i), rr);
  endtask

  initial begin
    #1;
    do_reset();

    fill(32'h1000, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    fill(32'h2000, 1'b0);
    cycle(1'b1, 32'hdead, 1'b0);
    cycle(1'b0, '0, 1'b0);

    do_reset();
    fill(32'h3000, 1'b0);
    cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1);

    fill(32'h4000, 1'b0);
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h5000 + WIDTH'(i), 1'b1);
    cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1);

    do_reset();
    fill(32'h6000, 1'b0);
    cycle(1'b0, '0, 1'b0);
    fill(32'h7000, 1'b0);
    cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1);

    do_reset();
    for (int i = 0; i < 1200; i++) begin
      if (i == 600) do_reset();
      cycle($urandom_range(0, 3) != 0, WIDTH'($urandom),
            (i < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) != 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
